// File: rtl/rsa_job_controller.sv
// rtl/rsa_job_controller.sv - job sequencer for the modular-exponentiation engine
// Screens degenerate moduli, launches the engine, and returns the result or a timeout error.
module rsa_job_controller #(
  parameter int WORDSIZE       = 16,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2*WORDSIZE-1:0] req_base,
  input  logic [2*WORDSIZE-1:0] req_modulo,
  input  logic [2*WORDSIZE-1:0] req_exponent,
  input  logic [TAG_W-1:0]      req_tag,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [2*WORDSIZE-1:0] resp_data,
  output logic                  resp_error,
  output logic [TAG_W-1:0]      resp_tag,
  output logic                  eng_start,
  output logic [2*WORDSIZE-1:0] eng_base,
  output logic [2*WORDSIZE-1:0] eng_modulo,
  output logic [2*WORDSIZE-1:0] eng_exponent,
  input  logic                  eng_finish,
  input  logic [2*WORDSIZE-1:0] eng_result
);

  localparam int W = 2 * WORDSIZE;
  localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   base_q, base_d;
  logic [W-1:0]   mod_q, mod_d;
  logic [W-1:0]   exp_q, exp_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [W-1:0]   data_q, data_d;
  logic           err_q, err_d;
  logic [15:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      mod_q   <= '0;
      exp_q   <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mod_q   <= mod_d;
      exp_q   <= exp_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    mod_d   = mod_q;
    exp_d   = exp_q;
    tag_d   = tag_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          base_d = req_base;
          mod_d  = req_modulo;
          exp_d  = req_exponent;
          tag_d  = req_tag;
          data_d = '0;
          err_d  = (req_modulo == '0);
          // Moduli 0 and 1 have a fixed answer, so the engine is never started.
          if (req_modulo == '0 || req_modulo == W'(1)) begin
            state_d = S_RESPOND;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = TIMEOUT_LD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Finish is tested first so a result on the last allowed cycle still wins.
        if (eng_finish) begin
          data_d  = eng_result;
          err_d   = 1'b0;
          state_d = S_RESPOND;
        end else if (cnt_q <= 16'd1) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESPOND;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_RESPOND: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready    = (state_q == S_IDLE);
  assign resp_valid   = (state_q == S_RESPOND);
  assign eng_start    = (state_q == S_LAUNCH);
  assign resp_data    = data_q;
  assign resp_error   = err_q;
  assign resp_tag     = tag_q;
  assign eng_base     = base_q;
  assign eng_modulo   = mod_q;
  assign eng_exponent = exp_q;

endmodule

// File: tb/tb_rsa_job_controller.sv
// tb/tb_rsa_job_controller.sv - self-checking bench for rsa_job_controller
// Behavioural engine plus arithmetic reference; table vectors, random jobs and corner sequences.
module tb_rsa_job_controller;

  localparam int WS = 16;
  localparam int W  = 32;
  localparam int TW = 4;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_base, req_modulo, req_exponent;
  logic [TW-1:0] req_tag;
  logic          resp_valid;
  logic          resp_ready;
  logic [W-1:0]  resp_data;
  logic          resp_error;
  logic [TW-1:0] resp_tag;
  logic          eng_start;
  logic [W-1:0]  eng_base, eng_modulo, eng_exponent;
  logic          eng_finish;
  logic [W-1:0]  eng_result;

  logic          model_finish = 1'b0;
  logic          inject_finish = 1'b0;
  logic [W-1:0]  model_res = '0;
  logic          eng_busy = 1'b0;
  int            eng_cnt = 0;
  int            eng_lat_cfg = 2;
  int            start_count = 0;
  int            checks = 0;
  int            failures = 0;

  assign eng_finish = model_finish | inject_finish;
  assign eng_result = model_res;

  always #5 clk = ~clk;

  rsa_job_controller #(.WORDSIZE(WS), .TAG_W(TW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_modulo(req_modulo), .req_exponent(req_exponent), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_error(resp_error), .resp_tag(resp_tag),
    .eng_start(eng_start), .eng_base(eng_base), .eng_modulo(eng_modulo), .eng_exponent(eng_exponent),
    .eng_finish(eng_finish), .eng_result(eng_result)
  );

  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                          input logic [W-1:0] m);
    logic [63:0] r, x, mm;
    mm = {32'd0, m};
    r  = 64'd1;
    x  = {32'd0, b} % mm;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[W-1:0];
  endfunction

  // Engine: computes from the operands it sees at start; lat_cfg < 0 means it hangs.
  always @(posedge clk) begin
    model_finish <= 1'b0;
    if (eng_start) begin
      eng_busy    <= 1'b1;
      eng_cnt     <= eng_lat_cfg;
      model_res   <= modexp(eng_base, eng_exponent, eng_modulo);
      start_count <= start_count + 1;
    end else if (eng_busy && eng_lat_cfg >= 0) begin
      if (eng_cnt <= 0) begin
        model_finish <= 1'b1;
        eng_busy     <= 1'b0;
      end else begin
        eng_cnt <= eng_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic ref_job(input logic [W-1:0] b, input logic [W-1:0] m, input logic [W-1:0] e,
                         output logic [W-1:0] d, output logic err);
    if (m == 0) begin d = '0; err = 1'b1; end
    else if (m == 1) begin d = '0; err = 1'b0; end
    else begin d = modexp(b, e, m); err = 1'b0; end
  endtask

  task automatic send(input logic [W-1:0] b, input logic [W-1:0] m, input logic [W-1:0] e,
                      input logic [TW-1:0] t);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("req_ready_before_send", req_ready, 1);
    req_base = b; req_modulo = m; req_exponent = e; req_tag = t;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name, input logic [W-1:0] d, input logic err,
                           input logic [TW-1:0] t, output int cyc);
    cyc = 1;
    while (!resp_valid && cyc < 400) begin @(negedge clk); cyc++; end
    chk({name, "_valid"}, resp_valid, 1);
    chk({name, "_data"}, resp_data, d);
    chk({name, "_error"}, resp_error, err);
    chk({name, "_tag"}, resp_tag, t);
  endtask

  task automatic hold_stable(input string name, input int n, input logic [W-1:0] d,
                             input logic err, input logic [TW-1:0] t);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== d || resp_error !== err ||
          resp_tag !== t || req_ready !== 1'b0 || eng_start !== 1'b0) bad++;
    end
    chk({name, "_stable_cycles_bad"}, bad, 0);
  endtask

  task automatic handshake(input string name);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({name, "_released"}, resp_valid, 0);
    chk({name, "_idle"}, req_ready, 1);
  endtask

  task automatic run_job(input string name, input logic [W-1:0] b, input logic [W-1:0] m,
                         input logic [W-1:0] e, input logic [TW-1:0] t, input int hold);
    logic [W-1:0] d;
    logic         err;
    int           s0, cyc;
    ref_job(b, m, e, d, err);
    s0 = start_count;
    send(b, m, e, t);
    chk({name, "_start"}, eng_start, (m > 1) ? 1 : 0);
    chk({name, "_opbase"}, eng_base, b);
    chk({name, "_opexp"}, eng_exponent, e);
    wait_resp(name, d, err, t, cyc);
    if (m < 2) chk({name, "_latency"}, cyc, 1);
    chk({name, "_nstarts"}, start_count - s0, (m > 1) ? 1 : 0);
    if (hold > 0) hold_stable(name, hold, d, err, t);
    handshake(name);
  endtask

  typedef struct {
    logic [W-1:0]  b, m, e;
    logic [TW-1:0] t;
    logic [W-1:0]  d;
    logic          err;
  } vec_t;

  initial begin
    vec_t vt[6];
    int   cyc;
    vt[0] = '{b: 65,   m: 3233, e: 17,   t: 1, d: 2790, err: 0};
    vt[1] = '{b: 2790, m: 3233, e: 2753, t: 2, d: 65,   err: 0};
    vt[2] = '{b: 4,    m: 497,  e: 13,   t: 3, d: 445,  err: 0};
    vt[3] = '{b: 1234, m: 0,    e: 5,    t: 4, d: 0,    err: 1};
    vt[4] = '{b: 1234, m: 1,    e: 5,    t: 5, d: 0,    err: 0};
    vt[5] = '{b: 77,   m: 3233, e: 0,    t: 6, d: 1,    err: 0};

    reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_base = '0; req_modulo = '0; req_exponent = '0; req_tag = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_error", resp_error, 0);
    chk("rst_eng_modulo", eng_modulo, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table vectors: expected values are hand-computed constants.
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] d;
      logic         err;
      ref_job(vt[i].b, vt[i].m, vt[i].e, d, err);
      chk($sformatf("vec%0d_ref", i), {d, 31'd0, err}, {vt[i].d, 31'd0, vt[i].err});
      eng_lat_cfg = 2 + i;
      run_job($sformatf("vec%0d", i), vt[i].b, vt[i].m, vt[i].e, vt[i].t, i % 2);
    end

    // Timeout: hung engine, then a late finish must not disturb the error response.
    eng_lat_cfg = -1;
    send(32'd65, 32'd3233, 32'd17, 4'd9);
    chk("to_start", eng_start, 1);
    wait_resp("to", '0, 1'b1, 4'd9, cyc);
    chk("to_latency", cyc, TO + 2);
    repeat (4) @(negedge clk);
    inject_finish = 1'b1;
    @(negedge clk);
    inject_finish = 1'b0;
    hold_stable("to_late_finish", 2, '0, 1'b1, 4'd9);
    handshake("to");
    eng_lat_cfg = 4;
    run_job("after_to", 32'd2790, 32'd3233, 32'd2753, 4'd10, 0);

    // Backpressure with a second request waiting behind the response.
    eng_lat_cfg = 3;
    send(32'd65, 32'd3233, 32'd17, 4'd11);
    wait_resp("bp", 32'd2790, 1'b0, 4'd11, cyc);
    req_base = 32'd4; req_modulo = 32'd497; req_exponent = 32'd13; req_tag = 4'd12;
    req_valid = 1'b1;
    hold_stable("bp", 50, 32'd2790, 1'b0, 4'd11);
    handshake("bp");
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_second_start", eng_start, 1);
    wait_resp("bp2", 32'd445, 1'b0, 4'd12, cyc);
    handshake("bp2");

    // Asynchronous reset in the middle of WAIT.
    eng_lat_cfg = -1;
    send(32'd65, 32'd3233, 32'd17, 4'd7);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 1);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_eng_base", eng_base, 0);
    chk("arst_resp_tag", resp_tag, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_no_resp", resp_valid, 0);
    eng_lat_cfg = 5;
    run_job("arst_next", 32'd2790, 32'd3233, 32'd2753, 4'd8, 0);

    // Random jobs against the arithmetic reference, with stray finishes while idle.
    for (int k = 0; k < 25; k++) begin
      logic [W-1:0] b, m, e;
      int sel;
      sel = $urandom_range(0, 9);
      b = $urandom; e = $urandom; m = $urandom;
      if (sel == 0) m = '0;
      else if (sel == 1) m = 32'd1;
      else if (m < 2) m = m + 2;
      eng_lat_cfg = $urandom_range(0, 40);
      if ($urandom_range(0, 3) == 0) begin
        inject_finish = 1'b1;
        @(negedge clk);
        inject_finish = 1'b0;
      end
      run_job($sformatf("rnd%0d", k), b, m, e, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
